// File: rtl/grf_mp.sv
// Multi-port general register file with write-through read bypass, a $gp/$sp
// reset image and a sequential soft-clear sweep engine.
module grf_mp #(
   parameter int              DW      = 32,
   parameter int              AW      = 5,
   parameter int              NUM_RD  = 2,
   parameter int              GP_IDX  = 28,
   parameter logic [DW-1:0]   GP_INIT = 32'h0000_1800,
   parameter int              SP_IDX  = 29,
   parameter logic [DW-1:0]   SP_INIT = 32'h0000_2ffc
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   input  logic                 we0,
   input  logic [AW-1:0]        waddr0,
   input  logic [DW-1:0]        wdata0,
   input  logic                 we1,
   input  logic [AW-1:0]        waddr1,
   input  logic [DW-1:0]        wdata1,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_idx;
   logic          r_busy;
   logic          r_done;
   logic          w_idle;

   function automatic logic [DW-1:0] resetVal(input logic [AW-1:0] a);
      if (a == AW'(GP_IDX)) return GP_INIT;
      else if (a == AW'(SP_IDX)) return SP_INIT;
      return '0;
   endfunction

   assign w_idle   = (r_state == S_IDLE);
   assign clr_busy = r_busy;
   assign clr_done = r_done;

   // Port 1 is written after port 0 so it wins a same-address collision;
   // register 0 is never written and stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= resetVal(AW'(i));
      end else if (r_state == S_IDLE) begin
         if (we0 && waddr0 != '0) r_mem[waddr0] <= wdata0;
         if (we1 && waddr1 != '0) r_mem[waddr1] <= wdata1;
      end else if (r_state == S_SWEEP) begin
         r_mem[r_idx] <= resetVal(r_idx);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= AW'(1);
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_idx   <= (r_state == S_SWEEP && w_next == S_SWEEP) ? r_idx + AW'(1) : AW'(1);
         r_busy  <= (w_next == S_SWEEP);
         r_done  <= (w_next == S_DONE);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (clr_req) w_next = S_SWEEP;
         S_SWEEP: if (r_idx == AW'(DEPTH - 1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bypass only while idle, since writes are dropped during the sweep.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr[k*AW +: AW];
      assign rd_data[k*DW +: DW] =
         (w_addr == '0)                         ? '0     :
         (w_idle && we1 && waddr1 == w_addr)    ? wdata1 :
         (w_idle && we0 && waddr0 == w_addr)    ? wdata0 :
                                                  r_mem[w_addr];
   end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: table-driven read/write vectors through a
// scoreboard queue, plus hand-written soft-clear and mid-sweep reset sequences.
module tb_grf_mp;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        we0;
   logic [4:0]  waddr0;
   logic [31:0] wdata0;
   logic        we1;
   logic [4:0]  waddr1;
   logic [31:0] wdata1;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;
   logic        clkEn;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t         vecs [12];
   logic [63:0]  expQ [$];

   grf_mp dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .we0      (we0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1      (we1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   always #5 if (clkEn) clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pop the oldest expected read pair and compare both read ports.
   task automatic popCompare(input string name);
      logic [63:0] e;
      if (expQ.size() == 0) begin
         checkOutput({name, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         checkOutput({name, "_p0"}, rd_data[31:0], e[31:0]);
         checkOutput({name, "_p1"}, rd_data[63:32], e[63:32]);
      end
   endtask

   task automatic readCheck(input string name, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
      rd_addr = {a1, a0};
      expQ.push_back({e1, e0});
      #1;
      popCompare(name);
   endtask

   task automatic applyStimulus(input string name, input vec_t v);
      @(negedge clk);
      we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
      we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
      rd_addr = {v.ra1, v.ra0};
      expQ.push_back({v.e1, v.e0});
      #1;
      popCompare(name);
   endtask

   // One clr_req pulse, then watch busy/done for a fixed window. stallAt
   // drives a write on that sweep cycle; resetAt pulses rst on that cycle.
   task automatic runSweep(input string name, input int stallAt, input int resetAt,
                           output int busyCnt, output int doneCnt, output int gap);
      int firstBusy;
      int doneAt;
      firstBusy = -1;
      doneAt    = -1;
      busyCnt   = 0;
      doneCnt   = 0;
      @(negedge clk);
      we0 = 0; we1 = 0;
      clr_req = 1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         clr_req = 0;
         we0     = 0;
         if (clr_busy) begin
            busyCnt++;
            if (firstBusy < 0) firstBusy = c;
         end
         if (clr_done) begin
            doneCnt++;
            doneAt = c;
            checkOutput({name, "_busyInDone"}, {31'd0, clr_busy}, 32'd0);
         end
         if (clr_busy && busyCnt == stallAt) begin
            we0 = 1; waddr0 = 5'd20; wdata0 = 32'h0000_DEAD;
            readCheck({name, "_noBypass"}, 5'd20, 5'd3, 32'd0, 32'd0);
         end
         if (clr_busy && busyCnt == resetAt) begin
            #1 rst = 0;
            #1 checkOutput({name, "_busyAsyncDrop"}, {31'd0, clr_busy}, 32'd0);
            readCheck({name, "_rstImage"}, 5'd28, 5'd5, 32'h0000_1800, 32'd0);
            rst = 1;
         end
      end
      gap = (doneAt >= 0 && firstBusy >= 0) ? doneAt - firstBusy : -1;
   endtask

   initial begin
      int bc, dc, gp;
      vecs[0]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         5'd28, 5'd29, 32'h0000_1800, 32'h0000_2ffc};
      vecs[1]  = '{1, 5'd8,  32'hAAAA_0000, 1, 5'd8,  32'h5555_1111, 5'd8,  5'd0,  32'h5555_1111, 32'h0};
      vecs[2]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         5'd8,  5'd5,  32'h5555_1111, 32'h0};
      vecs[3]  = '{0, 5'd0,  32'h0,         1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd8,  32'h0,         32'h5555_1111};
      vecs[4]  = '{1, 5'd0,  32'h1234,      0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
      vecs[5]  = '{1, 5'd3,  32'h1234,      0, 5'd0,  32'h0,         5'd3,  5'd31, 32'h1234,      32'h0};
      vecs[6]  = '{1, 5'd31, 32'h7,         1, 5'd28, 32'h9999,      5'd28, 5'd31, 32'h9999,      32'h7};
      vecs[7]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         5'd3,  5'd28, 32'h1234,      32'h9999};
      vecs[8]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         5'd31, 5'd29, 32'h7,         32'h0000_2ffc};
      vecs[9]  = '{1, 5'd10, 32'hA,         1, 5'd11, 32'hB,         5'd10, 5'd11, 32'hA,         32'hB};
      vecs[10] = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         5'd10, 5'd11, 32'hA,         32'hB};
      vecs[11] = '{1, 5'd12, 32'hC,         1, 5'd13, 32'hD,         5'd12, 5'd12, 32'hC,         32'hC};

      clk = 0; clkEn = 0; rst = 1; clr_req = 0;
      we0 = 0; waddr0 = 0; wdata0 = 0; we1 = 0; waddr1 = 0; wdata1 = 0; rd_addr = 0;

      // Reset image must be visible with the clock stopped.
      #2 rst = 0;
      #2;
      readCheck("rstImgA", 5'd0, 5'd28, 32'd0, 32'h0000_1800);
      readCheck("rstImgB", 5'd29, 5'd5, 32'h0000_2ffc, 32'd0);
      checkOutput("rstBusy", {31'd0, clr_busy}, 32'd0);
      checkOutput("rstDone", {31'd0, clr_done}, 32'd0);
      rst = 1;
      #2 clkEn = 1;

      for (int i = 0; i < 12; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      we0 = 0; we1 = 0;
      readCheck("postVec", 5'd12, 5'd13, 32'hC, 32'hD);

      runSweep("clr1", 10, 0, bc, dc, gp);
      checkOutput("clr1_busyCycles", bc, 32'd31);
      checkOutput("clr1_doneCycles", dc, 32'd1);
      checkOutput("clr1_doneGap",    gp, 32'd31);
      readCheck("clr1_r3r28",  5'd3,  5'd28, 32'd0, 32'h0000_1800);
      readCheck("clr1_r31r20", 5'd31, 5'd20, 32'd0, 32'd0);
      readCheck("clr1_r29r8",  5'd29, 5'd8,  32'h0000_2ffc, 32'd0);

      applyStimulus("preRst", '{1, 5'd5, 32'h55, 1, 5'd28, 32'h4444, 5'd5, 5'd28, 32'h55, 32'h4444});
      @(negedge clk);
      we0 = 0; we1 = 0;
      readCheck("preRstHeld", 5'd5, 5'd28, 32'h55, 32'h4444);

      runSweep("clrRst", 0, 15, bc, dc, gp);
      checkOutput("clrRst_busyCycles", bc, 32'd15);
      checkOutput("clrRst_doneCycles", dc, 32'd0);
      readCheck("clrRst_after", 5'd28, 5'd29, 32'h0000_1800, 32'h0000_2ffc);

      runSweep("clr2", 0, 0, bc, dc, gp);
      checkOutput("clr2_busyCycles", bc, 32'd31);
      checkOutput("clr2_doneCycles", dc, 32'd1);
      checkOutput("clr2_doneGap",    gp, 32'd31);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; the next-generation GPR block for the CPU datapath.
- Provides NUM_RD combinational read ports with same-cycle write-through bypass and two write ports (e.g. ALU and load or dual-issue writeback).
- Provides a programmable reset image for $gp/$sp and a sequential soft-clear sweep engine with busy/done handshake.
- Sits between decode (reads) and writeback (writes).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).
- GP_IDX, 28, index loaded with GP_INIT on reset/clear.
- GP_INIT, 32'h0000_1800, reset value of register GP_IDX.
- SP_IDX, 29, index loaded with SP_INIT on reset/clear.
- SP_INIT, 32'h0000_2ffc, reset value of register SP_IDX.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  packed read data; port k = bits [k*DW +: DW].
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- clr_req  in  1  soft-clear request (level, sampled in IDLE only).
- clr_busy  out  1  high while sweep in progress; writes ignored.
- clr_done  out  1  one-cycle pulse when sweep completes.

Behaviour:
- rst low (async): all registers cleared to 0, except GP_IDX = GP_INIT and SP_IDX = SP_INIT. FSM goes to IDLE, sweep index = 1, clr_busy = 0, clr_done = 0. rd_data reflects the reset image combinationally.
- Register 0:
  - reads always return 0;
  - writes to address 0 are discarded;
  - address 0 is never bypassed.
- Writes commit on the rising clk edge when the FSM is in IDLE.
- Write collision (we0 & we1, waddr0 == waddr1 != 0): port 1's data is stored; port 0's is dropped.
- Read port k is combinational, with this priority:
  - rd_addr k == 0 -> 0;
  - else we1 & waddr1 == rd_addr k & IDLE -> wdata1;
  - else we0 & waddr0 == rd_addr k & IDLE -> wdata0;
  - else stored value.
- Bypass is disabled outside IDLE; reads return stored values.
- FSM IDLE:
  - clr_req == 1 -> SWEEP; index = 1; clr_busy = 1 from the next cycle;
  - writes in the same cycle as an accepted clr_req still commit.
- FSM SWEEP:
  - each cycle, register[index] <= reset-image value for index; index increments;
  - the cycle index == DEPTH-1 goes to DONE;
  - duration is DEPTH-1 cycles (31 at default);
  - we0/we1 are ignored entirely, with no queuing; the pipeline stalls on clr_busy.
- FSM DONE:
  - clr_done = 1 and clr_busy = 0 for exactly one cycle, then IDLE;
  - index returns to 1;
  - clr_req is ignored in DONE; a held-high clr_req restarts the sweep from IDLE on the next cycle.
- Index counter is AW bits wide; wrap from DEPTH-1 never occurs because the FSM exits first.
- rst asserted mid-sweep: immediate full reset image, IDLE, clr_busy = 0, no clr_done pulse.
- All outputs are registered except rd_data.

Test Plan:
- Reset image: pulse rst low with clk stopped, read addresses 0, 28, 29, 5 -> 0, 32'h0000_1800, 32'h0000_2ffc, 0, available before any clock edge.
- Bypass and priority: we0 = 1, waddr0 = 8, wdata0 = 32'hAAAA_0000; we1 = 1, waddr1 = 8, wdata1 = 32'h5555_1111; rd_addr = 8 -> rd_data 5555_1111 in the same cycle. After the edge, with both we low, reg 8 reads 5555_1111.
- Zero register: we1 = 1, waddr1 = 0, wdata1 = 32'hFFFF_FFFF, rd_addr = 0 -> rd_data 0 both in the write cycle and after the edge.
- Soft clear:
  - Setup: preload reg 3 = 32'h1234, reg 28 = 32'h9999, reg 31 = 32'h7.
  - Stimulus: one-cycle clr_req.
  - Required response: clr_busy high for 31 cycles, then clr_done high exactly 1 cycle; afterwards reg 3 = 0, reg 28 = 32'h0000_1800, reg 31 = 0.
- Write blocked during sweep: at sweep cycle 10, we0 = 1, waddr0 = 20, wdata0 = 32'hDEAD -> no bypass (reads stored value). After done, reg 20 = 0.
- Reset mid-sweep: assert rst low at sweep cycle 15 -> clr_busy drops asynchronously, no clr_done pulse, reset image restored. After release, a fresh clr_req performs a full 31-cycle sweep.
